audio_frame_scheduler: RTL and testbench

AUDIO_FRAME_SCHEDULER -- requirements
Module: audio_frame_scheduler

---
 rtl/audio_frame_scheduler.sv | 122 ++++++++++++
 tb/tb_audio_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_frame_scheduler.sv
// Ping-pong frame buffer between a sample-rate synthesis chain and a byte-wide UART:
// one bank fills with quantised samples while the other drains as SYNC + BUF_LEN bytes.
module audio_frame_scheduler #(
   parameter int         BITS    = 16,
   parameter int         BUF_LEN = 32,
   parameter logic [7:0] SYNC    = 8'h80
) (
   input  logic            clk,
   input  logic            n_reset,
   input  logic            frame_tick,
   input  logic            sample_tick,
   input  logic [BITS-1:0] sample_in,
   output logic            dsp_ena,
   output logic [7:0]      tx_byte,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            overrun,
   output logic [7:0]      overrun_cnt,
   output logic [7:0]      frame_count
);

   localparam int IDX_W = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_LEN - 1);

   typedef enum logic {F_IDLE, F_FILL} fill_state_t;
   typedef enum logic [1:0] {D_IDLE, D_HDR, D_DATA} drain_state_t;

   fill_state_t      fill_state, fill_next;
   drain_state_t     drain_state, drain_next;
   logic [IDX_W-1:0] fill_idx, drain_idx;
   logic             fill_ptr, drain_ptr;
   logic [1:0]       full;
   logic [7:0]       mem [2][BUF_LEN];

   logic       write_en, fill_start, fill_done, drain_done, drop;
   logic [7:0] q_byte, wr_byte;

   // Quantise to the top byte; a byte that would look like a header is nudged off SYNC.
   assign q_byte     = sample_in[BITS-1 -: 8];
   assign wr_byte    = (q_byte == SYNC) ? SYNC + 8'd1 : q_byte;
   assign write_en   = (fill_state == F_FILL) && sample_tick;
   assign fill_done  = write_en && (fill_idx == LAST_IDX);
   assign fill_start = (fill_state == F_IDLE) && frame_tick && !full[fill_ptr];
   assign drop       = frame_tick && ((fill_state == F_FILL) || full[fill_ptr]);
   assign drain_done = (drain_state == D_DATA) && tx_ready && (drain_idx == LAST_IDX);
   assign dsp_ena    = (fill_state == F_FILL);

   // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
   always_comb begin
      fill_next = fill_state;
      case (fill_state)
         F_IDLE:  if (fill_start) fill_next = F_FILL;
         F_FILL:  if (fill_done)  fill_next = F_IDLE;
         default: fill_next = F_IDLE;
      endcase
   end

   always_comb begin
      drain_next = drain_state;
      tx_valid   = 1'b0;
      tx_byte    = 8'h00;
      case (drain_state)
         D_IDLE: if (full[drain_ptr]) drain_next = D_HDR;
         D_HDR: begin
            tx_valid = 1'b1;
            tx_byte  = SYNC;
            if (tx_ready) drain_next = D_DATA;
         end
         D_DATA: begin
            tx_valid = 1'b1;
            tx_byte  = mem[drain_ptr][drain_idx];
            if (drain_done) drain_next = D_IDLE;
         end
         default: drain_next = D_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         fill_state  <= F_IDLE;
         drain_state <= D_IDLE;
         fill_idx    <= '0;
         drain_idx   <= '0;
         fill_ptr    <= 1'b0;
         drain_ptr   <= 1'b0;
         full        <= 2'b00;
         overrun     <= 1'b0;
         overrun_cnt <= 8'd0;
         frame_count <= 8'd0;
      end else begin
         fill_state  <= fill_next;
         drain_state <= drain_next;
         overrun     <= drop;

         if (fill_start)    fill_idx <= '0;
         else if (write_en) fill_idx <= fill_idx + 1'b1;

         if ((drain_state == D_HDR) && tx_ready)       drain_idx <= '0;
         else if ((drain_state == D_DATA) && tx_ready) drain_idx <= drain_idx + 1'b1;

         // Fill and drain always target different banks, so set and clear never collide.
         if (fill_done) begin
            full[fill_ptr] <= 1'b1;
            fill_ptr       <= ~fill_ptr;
         end
         if (drain_done) begin
            full[drain_ptr] <= 1'b0;
            drain_ptr       <= ~drain_ptr;
            frame_count     <= frame_count + 8'd1;
         end

         if (drop && (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

   // NOTE: the sample store has no reset; its contents are only read after a complete fill.
   always_ff @(posedge clk) begin
      if (write_en) mem[fill_ptr][fill_idx] <= wr_byte;
   end

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler: fill/drain, escaping, back-pressure,
// overrun, back-to-back frames and reset abandonment.
module tb_audio_frame_scheduler;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        frame_tick, sample_tick, tx_ready;
   logic [15:0] sample_in;
   logic        dsp_ena, tx_valid, overrun;
   logic [7:0]  tx_byte, overrun_cnt, frame_count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [7:0]  rx_q[$];
   int          valid_falls = 0;
   logic        prev_valid = 1'b0;
   logic [15:0] smp [32];

   audio_frame_scheduler #(.BITS(16), .BUF_LEN(32), .SYNC(8'h80)) dut (
      .clk         (clk),
      .n_reset     (n_reset),
      .frame_tick  (frame_tick),
      .sample_tick (sample_tick),
      .sample_in   (sample_in),
      .dsp_ena     (dsp_ena),
      .tx_byte     (tx_byte),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .overrun     (overrun),
      .overrun_cnt (overrun_cnt),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   // Byte collector and inter-frame gap detector.
   always @(posedge clk) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
      if (prev_valid && !tx_valid) valid_falls++;
      prev_valid = tx_valid;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_dsp_ena"},     dsp_ena,     0);
      check({pfx, "_tx_valid"},    tx_valid,    0);
      check({pfx, "_tx_byte"},     tx_byte,     0);
      check({pfx, "_overrun"},     overrun,     0);
      check({pfx, "_overrun_cnt"}, overrun_cnt, 0);
      check({pfx, "_frame_count"}, frame_count, 0);
   endtask

   task automatic set_ramp(input logic [7:0] base);
      for (int i = 0; i < 32; i++) smp[i] = {base + 8'(i), 8'h00};
   endtask

   task automatic fill_frame(input string tag);
      int hi = 0;
      check({tag, "_dsp_ena_pre"}, dsp_ena, 0);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (dsp_ena) hi++;
         sample_in   = smp[i];
         sample_tick = 1'b1;
         step();
      end
      sample_tick = 1'b0;
      check({tag, "_dsp_ena_cycles"}, hi, 32);
      check({tag, "_dsp_ena_post"}, dsp_ena, 0);
   endtask

   task automatic wait_rx(input string tag, input int n);
      for (int c = 0; c < 300 && rx_q.size() < n; c++) step();
      check({tag, "_rx_count"}, rx_q.size(), n);
   endtask

   task automatic check_ramp_frame(input string tag, input int off, input logic [7:0] base);
      if (rx_q.size() >= off + 33) begin
         check({tag, "_hdr"}, rx_q[off], 8'h80);
         for (int i = 0; i < 32; i++) check({tag, "_data"}, rx_q[off + 1 + i], base + 8'(i));
      end
   endtask

   initial begin
      n_reset = 1'b0; frame_tick = 1'b0; sample_tick = 1'b0; tx_ready = 1'b0; sample_in = '0;
      step(); step();
      check_reset_outputs("por");
      n_reset = 1'b1;
      step();

      // Single frame, ramp 0x00..0x1F.
      tx_ready = 1'b1;
      rx_q.delete();
      set_ramp(8'h00);
      fill_frame("f1");
      check("f1_valid_before_hdr", tx_valid, 0);
      step();
      check("f1_hdr_valid", tx_valid, 1);
      check("f1_hdr_byte", tx_byte, 8'h80);
      wait_rx("f1", 33);
      check_ramp_frame("f1", 0, 8'h00);
      step(); step();
      check("f1_frame_count", frame_count, 1);
      check("f1_idle_valid", tx_valid, 0);

      // Quantisation and header escape.
      rx_q.delete();
      for (int i = 0; i < 32; i++) smp[i] = 16'h1234;
      smp[0] = 16'h8000; smp[1] = 16'h7FFF; smp[2] = 16'hFF00; smp[3] = 16'h80FF; smp[4] = 16'h8100;
      fill_frame("q");
      wait_rx("q", 33);
      if (rx_q.size() >= 33) begin
         check("q_hdr",    rx_q[0],  8'h80);
         check("q_8000",   rx_q[1],  8'h81);
         check("q_7fff",   rx_q[2],  8'h7F);
         check("q_ff00",   rx_q[3],  8'hFF);
         check("q_80ff",   rx_q[4],  8'h81);
         check("q_8100",   rx_q[5],  8'h81);
         check("q_last",   rx_q[32], 8'h12);
      end
      step(); step();
      check("q_frame_count", frame_count, 2);

      // Back-pressure after the third transferred byte.
      rx_q.delete();
      set_ramp(8'h40);
      fill_frame("bp");
      for (int c = 0; c < 20 && rx_q.size() < 3; c++) step();
      tx_ready = 1'b0;
      begin
         logic stable = 1'b1;
         for (int c = 0; c < 5; c++) begin
            if (!(tx_valid === 1'b1 && tx_byte === 8'h42)) stable = 1'b0;
            step();
         end
         check("bp_hold_stable", stable, 1);
      end
      check("bp_no_xfer", rx_q.size(), 3);
      tx_ready = 1'b1;
      wait_rx("bp", 33);
      check_ramp_frame("bp", 0, 8'h40);
      step(); step();
      check("bp_frame_count", frame_count, 3);

      // Both banks full with transmitter stalled, then a third request.
      tx_ready = 1'b0;
      rx_q.delete();
      set_ramp(8'h10);
      fill_frame("ov_a");
      fill_frame("ov_b");
      check("ov_hdr_stalled", tx_byte, 8'h80);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      check("ov_pulse", overrun, 1);
      check("ov_cnt", overrun_cnt, 1);
      check("ov_dsp_ena", dsp_ena, 0);
      step();
      check("ov_pulse_end", overrun, 0);
      check("ov_dsp_ena_after", dsp_ena, 0);
      check("ov_no_xfer", rx_q.size(), 0);

      // Reset while draining abandons everything.
      n_reset = 1'b0;
      #2;
      check_reset_outputs("rst_drain");
      step();
      n_reset = 1'b1;
      step();

      // Back-to-back frames: bank 0 drains while bank 1 fills.
      tx_ready = 1'b1;
      rx_q.delete();
      valid_falls = 0;
      set_ramp(8'h20);
      fill_frame("bb_a");
      set_ramp(8'h60);
      fill_frame("bb_b");
      check("bb_overlap", (rx_q.size() > 20) && (rx_q.size() < 33), 1);
      wait_rx("bb", 66);
      check_ramp_frame("bb_a", 0, 8'h20);
      check_ramp_frame("bb_b", 33, 8'h60);
      step(); step();
      check("bb_frame_count", frame_count, 2);
      check("bb_overrun_cnt", overrun_cnt, 0);
      check("bb_gaps", valid_falls, 2);

      // frame_tick during fill counts as a drop; reset at sample 10 abandons the frame.
      rx_q.delete();
      set_ramp(8'h00);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample_in   = 16'h5500;
         sample_tick = 1'b1;
         frame_tick  = (i == 5);
         step();
         if (i == 5) begin
            check("fill_drop_pulse", overrun, 1);
            check("fill_drop_cnt", overrun_cnt, 1);
            check("fill_drop_dsp_ena", dsp_ena, 1);
         end
      end
      sample_tick = 1'b0;
      frame_tick  = 1'b0;
      n_reset = 1'b0;
      #2;
      check_reset_outputs("rst_fill");
      step();
      n_reset = 1'b1;
      step();
      check("rst_fill_no_tx", rx_q.size(), 0);
      fill_frame("rf");
      wait_rx("rf", 33);
      check_ramp_frame("rf", 0, 8'h00);
      step(); step();
      check("rf_frame_count", frame_count, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
